periph_tx_buffer: RTL and testbench
===================================

Name: periph_tx_buffer

Overview:
- Downstream stage of a peripheral front-end such as the logic analyzer.
- Captures each 32-bit peripheral packet, which arrives as a one-cycle strobe with no backpressure, into a show-ahead FIFO.
- Presents packets to the host-side TX arbiter over a valid/ready handshake.
- Forces the peripheral-address field, drops packets on overflow and keeps counts.

Parameters:
- WIDTH, 32: packet width; bit layout fixed as [31:29] addr, [28] cfg, [27:26] nbytes, [25:24] rsvd, [23:0] data.
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- PERIPH_ADDR, 3'd0: value forced into bits [31:29] of every stored packet.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- packet_in  in  WIDTH  packet from the peripheral stage.
- in_valid  in  1  one-cycle strobe: packet_in is new this cycle.
- flush  in  1  synchronous clear of FIFO and counters.
- packet_out  out  WIDTH  head-of-FIFO packet.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  arbiter accepts packet_out this cycle.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one packet dropped since reset/flush.
- drop_count  out  16  cumulative dropped packets, saturating at 16'hFFFF.

Behaviour:
- Reset (rst=0, async): pointers=0, level=0, out_valid=0, packet_out=0, overflow=0, drop_count=0. Memory contents are don't-care.
- Storage: read/write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Pointers wrap naturally at 2*DEPTH.
- Push: in_valid=1 and (not full, or pop in the same cycle). Stores {PERIPH_ADDR, packet_in[28:0]}.
- Pop: out_valid=1 and out_ready=1. Advances the read pointer.
- Show-ahead: packet_out is registered and equals the head entry.
  - Write into an empty FIFO: out_valid rises, and packet_out is valid, the cycle after the push edge (latency 1).
  - After a pop, the next entry appears on the following cycle with no bubble while entries remain.
- Simultaneous push and pop:
  - Both occur and level is unchanged; this holds when full too.
  - When empty, only the push occurs (out_valid=0, so there is no pop).
- Overflow (in_valid=1, full, no pop):
  - Packet discarded.
  - drop_count increments unless already at FFFF.
  - overflow set.
  - FIFO contents and pointers unchanged.
- flush=1: next edge clears pointers, level, overflow and drop_count. flush takes priority over any push or pop that cycle; that push is neither stored nor counted.
- level reflects the registered occupancy after each edge. out_valid = (level != 0).
- Out-of-range bits: packet_in[28:0] is passed untouched; nbytes is not checked.
- Reset mid-transfer: all state is lost immediately. out_valid drops asynchronously with rst.

Optional Feature:
- Macro: PERIPH_TX_OVF_REPORT_EN.
- Defined:
  - A 16-bit pending-drop counter increments with drop_count.
  - When the pending counter is non-zero, the FIFO is not full and in_valid=0, a status packet is pushed: {PERIPH_ADDR, 1'b1, 2'b11, 2'b00, 8'hEE, pending}.
  - The pending counter clears that cycle. A drop in that same cycle is impossible because in_valid=0.
  - Peripheral pushes always win over status insertion.
  - drop_count stays cumulative.
  - flush clears the pending counter.
- Undefined: no pending counter and no status packets. Behaviour is exactly as above.

Test Plan:
- Basic: reset, PERIPH_ADDR=3'd5, push 32'h0A00_1234 with out_ready=1 -> next cycle out_valid=1, packet_out=32'hAA00_1234; popped; level returns 0.
- Fill: out_ready=0, push 16 packets 0..15 -> level=16. A 17th push leaves level=16, drop_count=1 and overflow=1. Draining yields data 0..15 in order, with no bubbles.
- Full plus simultaneous push/pop: FIFO full with out_ready=1 and in_valid=1 -> level stays 16 and drop_count unchanged. The new packet emerges after the 15 older entries.
- Flush: level=7, overflow=1, flush=1 with in_valid=1 -> next cycle level=0, out_valid=0, drop_count=0, overflow=0; the pushed packet is absent.
- Async reset: assert rst=0 mid-drain, between clock edges -> out_valid=0 and level=0 immediately. After release, the first push behaves as in the Basic test.
- Saturation, plus report with the macro defined:
  - Force 65537 overflow drops -> drop_count=16'hFFFF.
  - With the macro: after 3 drops, drain 1 entry and hold in_valid=0 -> status packet {addr,1,11,00,EE,0003} enqueued and the pending counter clears.

Source files
------------

// File: rtl/periph_tx_buffer.sv
// Show-ahead TX FIFO between a strobe-only peripheral stage and the host TX arbiter.
// Optional PERIPH_TX_OVF_REPORT_EN: queue a status packet carrying the drops since the last report.
module periph_tx_buffer #(
    parameter int         WIDTH       = 32,
    parameter int         DEPTH       = 16,
    parameter logic [2:0] PERIPH_ADDR = 3'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         packet_in,
    input  logic                     in_valid,
    input  logic                     flush,
    output logic [WIDTH-1:0]         packet_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: a packet transfers on a rising edge where out_valid and out_ready are both high.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_n;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             wr_en;
    logic             status_push;
    logic [WIDTH-1:0] status_word;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] head_n;
    logic [15:0]      drop_count_n;

    assign level     = wr_ptr - rd_ptr;
    assign out_valid = (level != '0);
    assign full      = (level == (AW+1)'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;
    assign wr_en     = push || status_push;
    assign wr_data   = push ? {PERIPH_ADDR, packet_in[WIDTH-4:0]} : status_word;

`ifdef PERIPH_TX_OVF_REPORT_EN
    logic [15:0] pending;

    assign status_push = !in_valid && (pending != 16'd0) && !full;
    assign status_word = WIDTH'({PERIPH_ADDR, 1'b1, 2'b11, 2'b00, 8'hEE, pending});

    // Tracks drop_count increments since the last status packet was queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 16'd0;
        end else if (flush) begin
            pending <= 16'd0;
        end else if (status_push) begin
            pending <= 16'd0;
        end else if (drop && drop_count != 16'hFFFF) begin
            pending <= pending + 16'd1;
        end
    end
`else
    assign status_push = 1'b0;
    assign status_word = '0;
`endif

    // The written slot becomes the new head only when it is the sole entry after this edge.
    always_comb begin
        rd_ptr_n = rd_ptr;
        if (pop) begin
            rd_ptr_n = rd_ptr + (AW+1)'(1);
        end
        head_n = mem[rd_ptr_n[AW-1:0]];
        if (wr_en && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
            head_n = wr_data;
        end
        drop_count_n = drop_count;
        if (drop && drop_count != 16'hFFFF) begin
            drop_count_n = drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            packet_out <= '0;
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            packet_out <= '0;
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            rd_ptr     <= rd_ptr_n;
            packet_out <= head_n;
            drop_count <= drop_count_n;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_periph_tx_buffer.sv
// Randomized scoreboard bench for periph_tx_buffer; the reference model is a packet count plus an expected queue.
// Honours PERIPH_TX_OVF_REPORT_EN in the model when the design is built with it.
`timescale 1ns/1ps
module tb_periph_tx_buffer;

    localparam int         DEPTH = 16;
    localparam logic [2:0] ADDR  = 3'd5;

    logic        clk;
    logic        rst;
    logic [31:0] packet_in;
    logic        in_valid;
    logic        flush;
    logic [31:0] packet_out;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    periph_tx_buffer #(.WIDTH(32), .DEPTH(DEPTH), .PERIPH_ADDR(ADDR)) dut (
        .clk(clk), .rst(rst), .packet_in(packet_in), .in_valid(in_valid), .flush(flush),
        .packet_out(packet_out), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [21:0] stat_q[$];
    logic        mon_en = 1'b0;

    int          m_cnt;
    logic        m_ovf;
    logic [15:0] m_drops;
    logic [15:0] m_pend;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_drops = 16'd0;
        m_pend  = 16'd0;
    endfunction

    // Predicts the effect of the next rising edge for the given inputs.
    function automatic void model_update(logic iv, logic [31:0] pkt, logic rdy, logic fl);
        logic do_pop;
        if (fl) begin
            model_clear();
            return;
        end
        do_pop = (m_cnt > 0) && rdy;
        if (iv) begin
            if (m_cnt < DEPTH || do_pop) begin
                exp_q.push_back({ADDR, pkt[28:0]});
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
                if (m_drops != 16'hFFFF) begin
                    m_drops++;
                    m_pend++;
                end
            end
        end
`ifdef PERIPH_TX_OVF_REPORT_EN
        else if (m_pend != 16'd0 && m_cnt < DEPTH) begin
            exp_q.push_back({ADDR, 1'b1, 2'b11, 2'b00, 8'hEE, m_pend});
            m_cnt++;
            m_pend = 16'd0;
        end
`endif
        if (do_pop) m_cnt--;
    endfunction

    task automatic step(input logic iv, input logic [31:0] pkt, input logic rdy, input logic fl);
        in_valid  = iv;
        packet_in = pkt;
        out_ready = rdy;
        flush     = fl;
        model_update(iv, pkt, rdy, fl);
        @(posedge clk);
        #2;
        stat_q.push_back({5'(m_cnt), m_ovf, m_drops});
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && m_cnt > 0; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("drain_empty", 32'(m_cnt), 32'd0);
    endtask

    task automatic async_reset();
        mon_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_packet_out", packet_out, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        model_clear();
        stat_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b1;
        stat_q.push_back(22'd0);
        mon_en = 1'b1;
    endtask

    // Monitor: status every cycle, packet content on every handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stat_q.size() == 0) begin
                chk("stat_queue_underrun", 32'd0, 32'd1);
            end else begin
                logic [21:0] st;
                st = stat_q.pop_front();
                chk("level", 32'(level), 32'(st[21:17]));
                chk("out_valid", 32'(out_valid), 32'(st[21:17] != 5'd0));
                chk("overflow", 32'(overflow), 32'(st[16]));
                chk("drop_count", 32'(drop_count), 32'(st[15:0]));
            end
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_packet", packet_out, 32'hDEAD_BEEF);
                end else begin
                    chk("packet_out", packet_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        packet_in = 32'd0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_packet_out", packet_out, 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        rst = 1'b1;
        stat_q.push_back(22'd0);
        mon_en = 1'b1;

        // Basic: one packet, address forced, latency one edge
        step(1'b1, 32'h0A00_1234, 1'b1, 1'b0);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_packet", packet_out, 32'hAA00_1234);
        drain();

        // Fill to full, one overflow, then drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'd16, 1'b0, 1'b0);
        drain();

        // Full plus simultaneous push/pop
        fill(DEPTH);
        step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        drain();

        // Flush with a concurrent push
        fill(7);
        step(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        chk("flush_exp_empty", 32'(exp_q.size()), 32'd0);

        // Async reset mid-drain, then basic again
        fill(5);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        async_reset();
        step(1'b1, 32'h0A00_1234, 1'b1, 1'b0);
        chk("post_arst_packet", packet_out, 32'hAA00_1234);
        drain();

        // Three drops, free one slot, then idle so a status packet can be queued
        fill(DEPTH);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        drain();

        // Randomized traffic with varying arbiter readiness
        for (int seg = 0; seg < 10; seg++) begin
            int rdy_pct;
            int iv_pct;
            rdy_pct = $urandom_range(10, 90);
            iv_pct  = $urandom_range(20, 90);
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 99) < iv_pct, $urandom,
                     $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 199) == 0);
            end
        end
        drain();

        // Drop counter saturation
        step(1'b0, 32'd0, 1'b0, 1'b1);
        fill(DEPTH);
        for (int i = 0; i < 65537; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        chk("drop_saturated", 32'(drop_count), 32'h0000_FFFF);
        drain();
        step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
